// File: rtl/addc16_stream_if.sv
// Operand-in / sum-out stream bundle for the add-with-carry engine.
interface addc16_stream_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x_a;
    logic [WIDTH-1:0] x_b;
    logic             cin;
    logic             in_first;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] wx;
    logic             out_first;
    logic             out_last;
    logic             cout;

    // Engine side.
    modport slave (
        input  in_valid, x_a, x_b, cin, in_first, in_last, out_ready,
        output in_ready, out_valid, wx, out_first, out_last, cout
    );

    // Producer/consumer side.
    modport master (
        output in_valid, x_a, x_b, cin, in_first, in_last, out_ready,
        input  in_ready, out_valid, wx, out_first, out_last, cout
    );
endinterface

// File: rtl/addc16_stream.sv
// Streaming multi-limb add-with-carry: LSB limb first, one limb per beat.
// Stage 1 precomputes sums for both carry-ins with a parallel-prefix
// network; stage 2 picks the real one from a 1-bit carry loop register.

// Parallel-prefix (Kogge-Stone, spans 1/2/4/8 for WIDTH=16) limb adder
// producing both carry-in variants plus block generate/propagate.
module addc16_prefix #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum0_o,
    output logic [WIDTH-1:0] sum1_o,
    output logic             bg_o,
    output logic             bp_o
);
    localparam int LVL = $clog2(WIDTH);

    logic [WIDTH-1:0] p_bit;
    logic [WIDTH-1:0] g_acc, p_acc, g_nxt, p_nxt;

    // Prefix levels: after level l each bit holds G/P over span 2^(l+1).
    always_comb begin
        p_bit = a_i ^ b_i;
        g_acc = a_i & b_i;
        p_acc = p_bit;
        g_nxt = '0;
        p_nxt = '0;
        for (int l = 0; l < LVL; l++) begin
            g_nxt = g_acc;
            p_nxt = p_acc;
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << l)) begin
                    g_nxt[i] = g_acc[i] | (p_acc[i] & g_acc[i-(1<<l)]);
                    p_nxt[i] = p_acc[i] & p_acc[i-(1<<l)];
                end
            end
            g_acc = g_nxt;
            p_acc = p_nxt;
        end
    end

    // Carry into bit i is the prefix over bits [i-1:0], with cin folded in.
    assign sum0_o = p_bit ^ {g_acc[WIDTH-2:0], 1'b0};
    assign sum1_o = p_bit ^ {g_acc[WIDTH-2:0] | p_acc[WIDTH-2:0], 1'b1};
    assign bg_o   = g_acc[WIDTH-1];
    assign bp_o   = p_acc[WIDTH-1];
endmodule

module addc16_stream #(
    parameter int WIDTH = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    addc16_stream_if.slave bus
);
    logic [WIDTH-1:0] pre_sum0, pre_sum1;
    logic             pre_bg, pre_bp;

    logic             s1_valid_q, s1_first_q, s1_last_q, s1_cin_q, s1_bg_q, s1_bp_q;
    logic [WIDTH-1:0] s1_sum0_q, s1_sum1_q;
    logic             s2_valid_q, s2_first_q, s2_last_q, s2_cout_q;
    logic [WIDTH-1:0] s2_wx_q;
    logic             carry_q;

    logic             s1_advance, in_accept, s2_load;
    logic             c_sel, carry_d, cout_d;
    logic [WIDTH-1:0] wx_d;

    addc16_prefix #(.WIDTH(WIDTH)) u_prefix (
        .a_i    (bus.x_a),
        .b_i    (bus.x_b),
        .sum0_o (pre_sum0),
        .sum1_o (pre_sum1),
        .bg_o   (pre_bg),
        .bp_o   (pre_bp)
    );

    assign s1_advance   = !s2_valid_q | bus.out_ready;
    assign bus.in_ready = !s1_valid_q | s1_advance;
    assign in_accept    = bus.in_valid & bus.in_ready;
    assign s2_load      = s1_valid_q & s1_advance;

    // Carry select: in_first restarts from cin, otherwise chain from the loop.
    always_comb begin
        c_sel   = s1_first_q ? s1_cin_q : carry_q;
        wx_d    = c_sel ? s1_sum1_q : s1_sum0_q;
        carry_d = s1_bg_q | (s1_bp_q & c_sel);
        cout_d  = s1_last_q & carry_d;
    end

    // Stage 1: capture both precomputed sums and limb framing on accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_cin_q   <= 1'b0;
            s1_bg_q    <= 1'b0;
            s1_bp_q    <= 1'b0;
            s1_sum0_q  <= '0;
            s1_sum1_q  <= '0;
        end else begin
            if (bus.in_ready) s1_valid_q <= bus.in_valid;
            if (in_accept) begin
                s1_first_q <= bus.in_first;
                s1_last_q  <= bus.in_last;
                s1_cin_q   <= bus.in_first & bus.cin;
                s1_bg_q    <= pre_bg;
                s1_bp_q    <= pre_bp;
                s1_sum0_q  <= pre_sum0;
                s1_sum1_q  <= pre_sum1;
            end
        end
    end

    // Stage 2: resolved sum limb; carry loop moves only on a real load and
    // is cleared after the last limb so it never leaks into the next operand.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid_q <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_cout_q  <= 1'b0;
            s2_wx_q    <= '0;
            carry_q    <= 1'b0;
        end else begin
            if (s1_advance) s2_valid_q <= s1_valid_q;
            if (s2_load) begin
                s2_wx_q    <= wx_d;
                s2_first_q <= s1_first_q;
                s2_last_q  <= s1_last_q;
                s2_cout_q  <= cout_d;
                carry_q    <= s1_last_q ? 1'b0 : carry_d;
            end
        end
    end

    // Outputs read as zero whenever no limb is presented.
    assign bus.out_valid = s2_valid_q;
    assign bus.wx        = s2_valid_q ? s2_wx_q : '0;
    assign bus.out_first = s2_valid_q & s2_first_q;
    assign bus.out_last  = s2_valid_q & s2_last_q;
    assign bus.cout      = s2_valid_q & s2_cout_q;
endmodule
